uart_rx_fifo_feeder: RTL and testbench

Serial receive front end sitting directly upstream of the async FIFO's write port, in the w_clk domain. It deserialises an 8N1 UART line into WIDTH-bit words and drives the FIFO write interface (data_out → data_in, w_en → w_en). It honours the FIFO full_flag by dropping the word and flagging overrun; it never writes while full. Frame and overrun errors are reported as single-cycle pulses for a downstream status block.

---
 rtl/uart_pkg.sv | 19 +
 rtl/sync_2ff.sv | 24 ++
 rtl/uart_rx_fifo_feeder.sv | 110 +++++++++++
 tb/tb_uart_rx_fifo_feeder.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM state encoding, default sizing and
// the baud counter width helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_CLK_DIV = 868;

  function automatic int baud_cnt_w(input int clk_div);
    return (clk_div > 1) ? $clog2(clk_div) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit; RST_VAL sets the
// value both flops load on reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_fifo_feeder.sv
// 8N1 UART receiver that writes each good word straight into the async FIFO
// write port, dropping it with an overrun pulse when the FIFO is full.
module uart_rx_fifo_feeder
  import uart_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic             w_clk,
  input  logic             rst,
  input  logic             rx_in,
  input  logic             fifo_full,
  output logic [WIDTH-1:0] data_out,
  output logic             w_en,
  output logic             frame_err,
  output logic             overrun_err,
  output logic             busy,
  output uart_state_e      state_dbg
);

  localparam int BAUD_W = baud_cnt_w(CLK_DIV);
  localparam int BIT_W  = $clog2(WIDTH + 1);
  localparam logic [BAUD_W-1:0] HALF_LIM = BAUD_W'(CLK_DIV / 2 - 1);
  localparam logic [BAUD_W-1:0] FULL_LIM = BAUD_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(WIDTH - 1);

  // FIFO write handshake: w_en is a one-cycle strobe and data_out is stable
  // while it is high; no write is issued when fifo_full is seen at the stop
  // sample, there is no back-pressure beyond that single sample.

  uart_state_e       state;
  logic              rx_s;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [WIDTH-1:0]  shift_reg;
  logic              baud_evt;

  sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
    .clk (w_clk),
    .rst (rst),
    .d   (rx_in),
    .q   (rx_s)
  );

  // START waits half a bit so every later sample lands mid-bit.
  assign baud_evt  = (baud_cnt == ((state == START) ? HALF_LIM : FULL_LIM));
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge w_clk) begin
    if (rst) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      data_out    <= '0;
      w_en        <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      w_en        <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (baud_evt) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= rx_s ? IDLE : DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_evt) begin
            baud_cnt  <= '0;
            shift_reg <= {rx_s, shift_reg[WIDTH-1:1]};
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) state <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_evt) begin
            baud_cnt <= '0;
            state    <= IDLE;
            if (rx_s && !fifo_full) begin
              data_out <= shift_reg;
              w_en     <= 1'b1;
            end else if (rx_s) begin
              overrun_err <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo_feeder.sv
// Directed bench for uart_rx_fifo_feeder at CLK_DIV=16, WIDTH=8 with a
// queue-based scoreboard checked by an independent output monitor.
module tb_uart_rx_fifo_feeder;
  import uart_pkg::*;

  localparam int W   = 8;
  localparam int DIV = 16;
  // sync (2) + idle detect (1) + half bit (8) + 8 data bits (128) + stop (16)
  localparam int LATENCY = 155;

  localparam logic [2:0] K_WEN = 3'b100;
  localparam logic [2:0] K_FRM = 3'b010;
  localparam logic [2:0] K_OVR = 3'b001;

  logic         w_clk = 1'b0;
  logic         rst;
  logic         rx_in;
  logic         fifo_full;
  logic [W-1:0] data_out;
  logic         w_en;
  logic         frame_err;
  logic         overrun_err;
  logic         busy;
  uart_state_e  state_dbg;

  logic [W+2:0] exp_q[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           start_cyc = 0;
  int           last_wen_cyc = -1;
  int           busy_cnt;

  uart_rx_fifo_feeder #(.WIDTH(W), .CLK_DIV(DIV)) dut (
    .w_clk       (w_clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .fifo_full   (fifo_full),
    .data_out    (data_out),
    .w_en        (w_en),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  // clock / cycle counter
  always #5 w_clk = ~w_clk;
  always @(posedge w_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge w_clk);
  endtask

  task automatic drive_bit(input logic b);
    rx_in = b;
    repeat (DIV) @(negedge w_clk);
  endtask

  // Full 8N1 frame; fifo_full is raised for the whole stop bit when asked.
  task automatic send_frame(input logic [W-1:0] d, input logic stop_bit, input logic full);
    @(negedge w_clk);
    rx_in = 1'b0;
    start_cyc = cyc;
    repeat (DIV) @(negedge w_clk);
    for (int i = 0; i < W; i++) drive_bit(d[i]);
    fifo_full = full;
    drive_bit(stop_bit);
    fifo_full = 1'b0;
    rx_in = 1'b1;
  endtask

  // monitor: pop and compare on every output pulse
  always @(negedge w_clk) begin
    if (!rst && (w_en || frame_err || overrun_err)) begin
      if (w_en) last_wen_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_pulse: got w_en/frm/ovr=%b data=0x%0h, expected none",
                 {w_en, frame_err, overrun_err}, data_out);
      end else begin
        logic [W+2:0] e;
        e = exp_q.pop_front();
        check("pulse_kind", {29'd0, w_en, frame_err, overrun_err}, {29'd0, e[W+2:W]});
        check("pulse_data", {24'd0, data_out}, {24'd0, e[W-1:0]});
      end
    end
  end

  initial begin
    rst = 1'b1;
    rx_in = 1'b1;
    fifo_full = 1'b0;
    repeat (3) @(posedge w_clk);
    @(negedge w_clk);
    check("rst_data_out", {24'd0, data_out}, 32'd0);
    check("rst_w_en", {31'd0, w_en}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_overrun_err", {31'd0, overrun_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, {30'd0, IDLE});
    rst = 1'b0;

    busy_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge w_clk);
      if (busy) busy_cnt++;
    end
    check("idle_busy_cycles", busy_cnt, 0);

    // single frame and its latency from the start edge
    exp_q.push_back({K_WEN, 8'hA5});
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(20);
    check("a5_latency", last_wen_cyc - start_cyc, LATENCY);

    // back-to-back frames, one-bit stop
    exp_q.push_back({K_WEN, 8'h00});
    exp_q.push_back({K_WEN, 8'hFF});
    exp_q.push_back({K_WEN, 8'h3C});
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(20);

    // stop bit low: frame error, data_out keeps 0x3C
    exp_q.push_back({K_FRM, 8'h3C});
    send_frame(8'h55, 1'b0, 1'b0);
    idle(40);

    // FIFO full at stop sample, then a normal frame
    exp_q.push_back({K_OVR, 8'h3C});
    exp_q.push_back({K_WEN, 8'h42});
    send_frame(8'h81, 1'b1, 1'b1);
    send_frame(8'h42, 1'b1, 1'b0);
    idle(20);

    // short start glitch: no pulse, back to idle
    @(negedge w_clk);
    rx_in = 1'b0;
    idle(4);
    rx_in = 1'b1;
    idle(30);
    check("glitch_busy", {31'd0, busy}, 32'd0);
    check("glitch_data_out", {24'd0, data_out}, 32'h42);

    // reset in the middle of data bit 4 of 0x99
    @(negedge w_clk);
    rx_in = 1'b0;
    idle(DIV);
    for (int i = 0; i < 4; i++) drive_bit(1'((8'h99 >> i) & 8'h01));
    rx_in = 1'b1;
    idle(DIV / 2);
    rst = 1'b1;
    idle(2);
    check("midrst_state", {30'd0, state_dbg}, {30'd0, IDLE});
    check("midrst_data_out", {24'd0, data_out}, 32'd0);
    rst = 1'b0;
    idle(40);
    check("midrst_busy", {31'd0, busy}, 32'd0);

    exp_q.push_back({K_WEN, 8'h99});
    send_frame(8'h99, 1'b1, 1'b0);
    idle(40);

    check("exp_q_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
